// File: rtl/uart_cmd_receiver.sv
// UART 8N1 command-frame receiver: header + two 16-bit operands.
// Decoded operands and op code are presented with a one-cycle cmd_valid strobe.
module uart_cmd_receiver #(
    parameter int CLKS_PER_BIT   = 868,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [15:0] num1,
    output logic [15:0] num2,
    output logic [1:0]  op,
    output logic        cmd_valid,
    output logic        frame_err,
    output logic        busy
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bState_t;
    typedef enum logic [2:0] {F_HDR, F_N1H, F_N1L, F_N2H, F_N2L} fState_t;

    bState_t       bState;
    fState_t       fState;
    logic          rxMeta, rxs;
    logic [CW-1:0] clkCnt;
    logic [2:0]    bitCnt;
    logic [7:0]    shiftReg;
    logic [TW-1:0] toCnt;
    logic [1:0]    opPend;
    logic [15:0]   hold1;
    logic [7:0]    hold2H;

    logic bitEnd, startEdge, byteDone, stopErr, timeoutHit;

    always_comb begin
        bitEnd     = (clkCnt == CW'(CLKS_PER_BIT - 1));
        startEdge  = (bState == B_IDLE) && !rxs;
        byteDone   = (bState == B_STOP) && bitEnd && rxs;
        stopErr    = (bState == B_STOP) && bitEnd && !rxs;
        // A start edge on the expiry cycle takes priority over the timeout.
        timeoutHit = (fState != F_HDR) && (bState == B_IDLE) && !startEdge &&
                     (toCnt >= TW'(TIMEOUT_CYCLES - 1));
    end

    assign busy = (fState != F_HDR) || (bState != B_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rxMeta    <= 1'b1;
            rxs       <= 1'b1;
            bState    <= B_IDLE;
            fState    <= F_HDR;
            clkCnt    <= '0;
            bitCnt    <= '0;
            shiftReg  <= '0;
            toCnt     <= '0;
            opPend    <= '0;
            hold1     <= '0;
            hold2H    <= '0;
            num1      <= '0;
            num2      <= '0;
            op        <= '0;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rxMeta    <= rx;
            rxs       <= rxMeta;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;

            case (bState)
                B_IDLE: if (!rxs) begin
                    bState <= B_START;
                    clkCnt <= '0;
                    bitCnt <= '0;
                end
                B_START: if (clkCnt == CW'(HALF - 1)) begin
                    clkCnt <= '0;
                    bState <= rxs ? B_IDLE : B_DATA;
                end else clkCnt <= clkCnt + 1'b1;
                B_DATA: if (bitEnd) begin
                    clkCnt   <= '0;
                    shiftReg <= {rxs, shiftReg[7:1]};
                    bitCnt   <= bitCnt + 1'b1;
                    if (bitCnt == 3'd7) bState <= B_STOP;
                end else clkCnt <= clkCnt + 1'b1;
                B_STOP: if (bitEnd) begin
                    clkCnt <= '0;
                    bState <= B_IDLE;
                end else clkCnt <= clkCnt + 1'b1;
                default: bState <= B_IDLE;
            endcase

            // Inter-byte idle timer, only meaningful inside a frame.
            if (fState == F_HDR || byteDone || timeoutHit) toCnt <= '0;
            else if (bState == B_IDLE && !startEdge)      toCnt <= toCnt + 1'b1;

            if (stopErr || timeoutHit) begin
                frame_err <= 1'b1;
                fState    <= F_HDR;
            end else if (byteDone) begin
                case (fState)
                    F_HDR: if (shiftReg[7:2] == 6'b101000) begin
                        opPend <= shiftReg[1:0];
                        fState <= F_N1H;
                    end else frame_err <= 1'b1;
                    F_N1H: begin hold1[15:8] <= shiftReg; fState <= F_N1L; end
                    F_N1L: begin hold1[7:0]  <= shiftReg; fState <= F_N2H; end
                    F_N2H: begin hold2H      <= shiftReg; fState <= F_N2L; end
                    F_N2L: begin
                        num1      <= hold1;
                        num2      <= {hold2H, shiftReg};
                        op        <= opPend;
                        cmd_valid <= 1'b1;
                        fState    <= F_HDR;
                    end
                    default: fState <= F_HDR;
                endcase
            end
        end
    end
endmodule
